// File: rtl/cg_pkg.sv
// cg_pkg: shared state encoding and FP32 field constants for the CG iteration controller
package cg_pkg;
   typedef enum logic [2:0] {S_IDLE, S_KICK, S_RUN, S_CHECK, S_WAIT_ITER, S_DONE} cg_state_t;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam logic [31:0] DEFAULT_TOLERANCE = 32'h283424DC;
endpackage

// File: rtl/fp32_nonneg_le.sv
// fp32_nonneg_le: a <= b for non-negative finite FP32, plus a flag for NaN/Inf/negative a
module fp32_nonneg_le
   import cg_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        le_o,
   output logic        nan_or_neg_o
);
   // positive finite FP32 values order exactly like their {exp,mant} bits as unsigned integers
   always_comb begin
      le_o = a_i[EXP_MSB:0] <= b_i[EXP_MSB:0];
      nan_or_neg_o = a_i[31] | (&a_i[EXP_MSB:EXP_LSB]);
   end
endmodule

// File: rtl/cg_convergence_ctrl.sv
// cg_convergence_ctrl: counts CG iterations, tests the residual norm against tolerance, re-arms or stops the ALU
module cg_convergence_ctrl
   import cg_pkg::*;
#(
   parameter int                       ELEMENT_WIDTH = 32,
   parameter logic [ELEMENT_WIDTH-1:0] TOLERANCE     = DEFAULT_TOLERANCE,
   parameter int                       MAX_ITER      = 1000,
   parameter int                       KICK_CYCLES   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_solve,
   input  logic [ELEMENT_WIDTH-1:0] rs_new,
   input  logic                     rs_new_valid,
   input  logic                     iter_done,
   output logic                     reset_vXv1,
   output logic                     reset_mXv1,
   output logic [15:0]              iteration_count,
   output logic [ELEMENT_WIDTH-1:0] last_rs,
   output logic                     busy,
   output logic                     done,
   output logic                     converged,
   output logic                     error
);
   cg_state_t                state_q;
   logic [3:0]               kick_q;
   logic [15:0]              iter_q, iter_d;
   logic [ELEMENT_WIDTH-1:0] last_rs_q;
   logic                     rst_alu_q, busy_q, done_q, conv_q, err_q, seen_q;
   logic                     le, bad, iter_end, term;

   fp32_nonneg_le u_cmp (
      .a_i          (last_rs_q),
      .b_i          (TOLERANCE),
      .le_o         (le),
      .nan_or_neg_o (bad)
   );

   // iteration-end and solve-termination decisions shared by CHECK and WAIT_ITER
   always_comb begin
      iter_d = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;
      iter_end = (state_q == S_WAIT_ITER && iter_done) ||
                 (state_q == S_CHECK && !bad && !le && (seen_q || iter_done));
      term = (state_q == S_RUN && !rs_new_valid && iter_done) ||
             (state_q == S_CHECK && (bad || le)) ||
             (iter_end && iter_d == 16'(MAX_ITER));
   end

   // controller FSM with registered outputs; termination overrides the re-arm path
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         kick_q    <= '0;
         iter_q    <= '0;
         last_rs_q <= '0;
         rst_alu_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         conv_q    <= 1'b0;
         err_q     <= 1'b0;
         seen_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start_solve) begin
               state_q <= S_KICK;
               kick_q  <= 4'(KICK_CYCLES);
               iter_q  <= '0;
               conv_q  <= 1'b0;
               err_q   <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b1;
            end
            S_KICK: if (kick_q == 4'd1) begin
               state_q   <= S_RUN;
               rst_alu_q <= 1'b0;
            end else kick_q <= kick_q - 4'd1;
            S_RUN: if (rs_new_valid) begin
               last_rs_q <= rs_new;
               seen_q    <= iter_done;
               state_q   <= S_CHECK;
            end else if (iter_done) err_q <= 1'b1;
            S_CHECK: if (bad) err_q <= 1'b1;
            else if (le) begin
               conv_q <= 1'b1;
               iter_q <= iter_d;
            end else if (!(seen_q || iter_done)) state_q <= S_WAIT_ITER;
            default: ;
         endcase
         if (iter_end) begin
            iter_q    <= iter_d;
            state_q   <= S_KICK;
            kick_q    <= 4'(KICK_CYCLES);
            rst_alu_q <= 1'b1;
         end
         if (term) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            rst_alu_q <= 1'b1;
         end
      end
   end

   assign reset_vXv1      = rst_alu_q;
   assign reset_mXv1      = rst_alu_q;
   assign iteration_count = iter_q;
   assign last_rs         = last_rs_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign converged       = conv_q;
   assign error           = err_q;
endmodule

// File: tb/tb_cg_convergence_ctrl.sv
// tb_cg_convergence_ctrl: directed and randomized solves checked against a transaction-level model
module tb_cg_convergence_ctrl;
   localparam int          KC  = 2;
   localparam int          MI  = 3;
   localparam logic [31:0] TOL = 32'h283424DC;

   logic        clk = 0, reset = 0, start_solve = 0, rs_new_valid = 0, iter_done = 0;
   logic [31:0] rs_new = 0;
   logic        reset_vXv1, reset_mXv1, busy, done, converged, error;
   logic [15:0] iteration_count;
   logic [31:0] last_rs;
   int          n_chk = 0, n_err = 0;
   logic [31:0] exp_cnt = 0, exp_last = 0;
   logic        exp_conv = 0, exp_err = 0, fin = 0;

   always #5 clk = ~clk;

   cg_convergence_ctrl #(.ELEMENT_WIDTH(32), .TOLERANCE(TOL), .MAX_ITER(MI), .KICK_CYCLES(KC)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_solve     (start_solve),
      .rs_new          (rs_new),
      .rs_new_valid    (rs_new_valid),
      .iter_done       (iter_done),
      .reset_vXv1      (reset_vXv1),
      .reset_mXv1      (reset_mXv1),
      .iteration_count (iteration_count),
      .last_rs         (last_rs),
      .busy            (busy),
      .done            (done),
      .converged       (converged),
      .error           (error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference verdict from real-valued FP32 semantics: 0 continue, 1 converged, 2 error
   function automatic int verdict(input logic [31:0] v);
      if (v[31] || v[30:23] == 8'hFF) return 2;
      return ($bitstoshortreal(v) <= $bitstoshortreal(TOL)) ? 1 : 0;
   endfunction

   task automatic reset_chk(input string tag);
      check({tag, "_alu"}, {reset_vXv1, reset_mXv1}, 2'b11);
      check({tag, "_flags"}, {busy, done, converged, error}, 4'b0000);
      check({tag, "_cnt"}, iteration_count, 0);
      check({tag, "_last"}, last_rs, 0);
   endtask

   task automatic wait_run();
      int c = 0;
      check("kick_alu", {reset_vXv1, reset_mXv1, busy}, 3'b111);
      while (reset_vXv1 && c < 20) begin
         tick();
         c++;
      end
      check("kick_len", c, KC);
      check("run_mxv", reset_mXv1, 0);
   endtask

   task automatic solve_start();
      start_solve = 1;
      tick();
      start_solve = 0;
      exp_cnt = 0; exp_conv = 0; exp_err = 0; fin = 0;
      check("start_done", done, 0);
      check("start_cnt", iteration_count, 0);
      wait_run();
   endtask

   task automatic finish_chk();
      check("fin_state", {done, busy, reset_vXv1, reset_mXv1}, 4'b1011);
      check("fin_conv", converged, exp_conv);
      check("fin_err", error, exp_err);
      check("fin_cnt", iteration_count, exp_cnt);
      check("fin_last", last_rs, exp_last);
   endtask

   // mode 0: iter_done without rs_new_valid, 1: both together, 2: rs_new_valid then iter_done later
   task automatic iter_step(input logic [31:0] v, input int mode, input int gap);
      repeat (gap) tick();
      if (mode == 0) begin
         iter_done = 1;
         tick();
         iter_done = 0;
         exp_err = 1; fin = 1;
      end else begin
         rs_new = v; rs_new_valid = 1; iter_done = (mode == 1);
         tick();
         rs_new_valid = 0; iter_done = 0; exp_last = v;
         check("check_last", last_rs, v);
         case (verdict(v))
            2: begin exp_err = 1; fin = 1; check("check_nodone", done, 0); tick(); end
            1: begin exp_conv = 1; exp_cnt++; fin = 1; check("check_nodone", done, 0); tick(); end
            default: begin
               tick();
               if (mode == 2) begin
                  check("wait_busy", {busy, reset_vXv1}, 2'b10);
                  if ($urandom_range(0, 1) == 1) begin
                     rs_new = $urandom; rs_new_valid = 1; start_solve = 1;
                     tick();
                     rs_new_valid = 0; start_solve = 0;
                     check("wait_ignore", last_rs, v);
                  end
                  repeat ($urandom_range(0, 2)) tick();
                  iter_done = 1;
                  tick();
                  iter_done = 0;
               end
               exp_cnt++;
               fin = (exp_cnt == MI);
            end
         endcase
      end
      if (fin) finish_chk();
      else begin
         check("iter_cnt", iteration_count, exp_cnt);
         wait_run();
      end
   endtask

   function automatic logic [31:0] pick_value();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4: return {1'b0, 8'($urandom_range(8'h51, 8'hFE)), 23'($urandom)};
         5: return {1'b0, 8'($urandom_range(0, 8'h4F)), 23'($urandom)};
         6: return TOL;
         7: return TOL + 32'd1;
         8: return $urandom_range(0, 1) ? {1'b1, 31'($urandom)} : {9'h0FF, 23'($urandom)};
         default: return 32'h3F800000;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int mode;
      repeat (3) tick();
      reset_chk("rst_low");
      reset = 1;
      tick();
      reset_chk("rst_idle");

      solve_start();
      iter_step(32'h3F800000, 2, 0);
      iter_step(32'h20000000, 2, 1);

      solve_start();
      iter_step(TOL, 2, 0);

      solve_start();
      iter_step(TOL + 32'd1, 2, 0);
      iter_step(32'h3F800000, 2, 2);
      iter_step(32'h3F800000, 2, 0);

      solve_start();
      iter_step(32'h7FC00000, 2, 1);

      solve_start();
      iter_step(32'h0, 0, 1);

      solve_start();
      iter_step(32'h00000001, 1, 0);

      solve_start();
      iter_step(32'h3F800000, 1, 0);
      iter_step(TOL, 1, 1);

      solve_start();
      rs_new = 32'h3F800000; rs_new_valid = 1;
      tick();
      rs_new_valid = 0;
      tick();
      reset = 0; iter_done = 1;
      tick();
      iter_done = 0; reset = 1;
      reset_chk("rst_mid");
      exp_last = 0;
      tick();
      reset_chk("rst_after");

      for (int s = 0; s < 30; s++) begin
         solve_start();
         while (!fin) begin
            mode = $urandom_range(0, 9);
            iter_step(pick_value(), mode == 0 ? 0 : (mode < 4 ? 1 : 2), $urandom_range(0, 2));
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
